sram_mem_ctrl: RTL and testbench
================================

# sram_mem_ctrl

Memory-stage SRAM controller: the consumer of the EXE→MEM pipeline register. Takes the registered ALU result (address), Rm value (store data) and memory read/write enables, performs one 32-bit word access over a 16-bit external asynchronous SRAM as two half-word phases, and returns the load data to the MEM→WB path. While an access is in flight it holds `ready` low so the hazard/freeze logic stalls every pipeline register.

## Interface
- `ADDR_W`, 32: CPU address/data width.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.
- `BASE`, 1024: CPU byte address mapped to SRAM half-word 0.
- `WAIT`, 2: cycles per half-word phase; legal range ≥ 2.

- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `wr_en`  in  1  store request (MEM_W_EN from EXE register).
- `rd_en`  in  1  load request (MEM_R_EN from EXE register).
- `address`  in  ADDR_W  byte address (ALU result).
- `wdata`  in  ADDR_W  store data (Val_Rm).
- `rdata`  out  ADDR_W  last loaded word.
- `ready`  out  1  high = MEM stage may advance; low = freeze pipeline.
- `sram_addr`  out  SRAM_ADDR_W  SRAM half-word address.
- `sram_dq_o`  out  16  data driven to SRAM.
- `sram_dq_i`  in  16  data returned from SRAM.
- `sram_dq_oe`  out  1  output enable for the board-level tri-state on DQ.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE: if `wr_en|rd_en`, latch `address`, `wdata` and the op (write wins if both asserted), clear the phase counter, then go to LO. Otherwise stay in IDLE.
- Address map: `word = (address - BASE) >> 2`. The subtraction is ADDR_W wide and wraps.
  - LO phase drives `sram_addr = {word[SRAM_ADDR_W-2:0], 1'b0}`.
  - HI phase drives `sram_addr = {word[SRAM_ADDR_W-2:0], 1'b1}`.
  - `address[1:0]` is ignored.
- LO/HI each last exactly WAIT cycles, counted by a phase counter.
- Write phase:
  - `sram_dq_oe=1` for the whole phase.
  - `sram_dq_o` = `wdata[15:0]` in LO, `wdata[31:16]` in HI.
  - `sram_we_n=0` on every phase cycle except the last, where it is 1. This gives a rising WE edge with address and data stable.
- Read phase:
  - `sram_oe_n=0` and `sram_dq_oe=0`.
  - `sram_dq_i` is sampled at the clock edge that ends the phase: into `rdata[15:0]` for LO, `rdata[31:16]` for HI.
- Transitions: LO → HI after WAIT cycles; HI → DONE after WAIT cycles; DONE → IDLE unconditionally.
- `ready` is combinational: `(IDLE && !(wr_en|rd_en)) || DONE`.
- `rdata` changes only on read-phase sample edges. Writes never modify it. It holds its value between loads.
- Outside LO/HI: `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, and `sram_addr`/`sram_dq_o` hold their last values.

## Timing
- Reset values: state IDLE, `rdata=0`, `sram_addr=0`, `sram_dq_o=0`, `sram_dq_oe=0`, `sram_we_n=1`, `sram_oe_n=1`. `ready` follows its equation (1 if no request).
- Access latency: request seen in IDLE at cycle 0; LO covers cycles 1..WAIT; HI covers WAIT+1..2·WAIT; DONE at 2·WAIT+1.
  - `ready` is low for 2·WAIT+1 cycles and high in DONE.
  - The EXE/MEM register advances at the edge ending DONE.
- Load data is valid in `rdata` from the DONE cycle onward, which is when MEM→WB captures it.
- Back-to-back accesses: a new request presented after DONE is taken in the following IDLE cycle. There is no dead cycle beyond IDLE.
- Request inputs are ignored outside IDLE. The stalled EXE register keeps them stable.
- Reset mid-access: the FSM immediately returns to IDLE and strobes go inactive asynchronously. A partially written word (low half only) is acceptable. `rdata` is cleared to 0.

## Test plan
- Reset/idle: assert `rst` with no requests → all outputs at their reset values and `ready=1` throughout.
- Store, WAIT=2: `address=1032`, `wdata=0xDEADBEEF`.
  - `sram_addr=4` with `dq_o=0xBEEF` for 2 cycles, then `sram_addr=5` with `0xDEAD`.
  - `we_n` pattern 0,1,0,1.
  - `ready` low for 5 cycles, then high for 1.
- Load from the same address with an SRAM model → `rdata=0xDEADBEEF` in DONE; `oe_n=0` and `dq_oe=0` during LO/HI.
- Back-to-back: store `0x12345678`@1024 then load @1024 → second access starts in the IDLE cycle immediately after DONE, `rdata=0x12345678`, and no spurious `we_n` pulse.
- Both `wr_en` and `rd_en` high → a write is performed and `rdata` is unchanged.
- Assert `rst` during HI of a load → FSM in IDLE the same cycle, `we_n=1`, `oe_n=1`, `rdata=0`, `ready=1` once the request drops.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage controller that does one 32-bit word access as two
// 16-bit half-word phases on an external asynchronous SRAM. While an access
// is in flight, ready is held low so the pipeline freezes.
module sram_mem_ctrl #(
   parameter int          ADDR_W      = 32,
   parameter int          SRAM_ADDR_W = 18,
   parameter int unsigned BASE        = 1024,
   parameter int          WAIT        = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      address,
   input  logic [ADDR_W-1:0]      wdata,
   output logic [ADDR_W-1:0]      rdata,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_o,
   input  logic [15:0]            sram_dq_i,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
);

   localparam int CW = (WAIT > 2) ? $clog2(WAIT) : 1;
   localparam logic [ADDR_W-1:0] BASE_V = ADDR_W'(BASE);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            op_wr;
   logic [15:0]     wdata_hi;
   logic [ADDR_W-1:0] diff;
   logic            req, last, phase;
   logic            unused_bits;

   assign req   = wr_en | rd_en;
   assign last  = (cnt == CW'(WAIT - 1));
   assign phase = (state == LO) || (state == HI);

   // Byte offset from BASE, wrapping; word index is diff >> 2
   assign diff        = address - BASE_V;
   assign unused_bits = ^{diff[ADDR_W-1:SRAM_ADDR_W+1], diff[1:0]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic: each half-word phase lasts WAIT cycles
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req)  state_nx = LO;
         LO:   if (last) state_nx = HI;
         HI:   if (last) state_nx = DONE;
         DONE:           state_nx = IDLE;
         default:        state_nx = IDLE;
      endcase
   end

   // Strobes and ready: combinational from state so reset kills them at once.
   // WE rises on the last phase cycle with address/data still stable.
   always_comb begin
      sram_we_n  = !(phase && op_wr && !last);
      sram_oe_n  = !(phase && !op_wr);
      sram_dq_oe = phase && op_wr;
      ready      = ((state == IDLE) && !req) || (state == DONE);
   end

   // Datapath: latch request, step address/data per phase, sample load data
   // at the edge that ends each read phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         op_wr     <= 1'b0;
         wdata_hi  <= '0;
         sram_addr <= '0;
         sram_dq_o <= '0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               op_wr     <= wr_en;
               wdata_hi  <= wdata[31:16];
               cnt       <= '0;
               sram_addr <= {diff[SRAM_ADDR_W:2], 1'b0};
               sram_dq_o <= wdata[15:0];
            end
            LO: if (last) begin
               cnt          <= '0;
               sram_addr[0] <= 1'b1;
               sram_dq_o    <= wdata_hi;
               if (!op_wr) rdata[15:0] <= sram_dq_i;
            end else begin
               cnt <= cnt + 1'b1;
            end
            HI: if (last) begin
               cnt <= '0;
               if (!op_wr) rdata[31:16] <= sram_dq_i;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed testbench for sram_mem_ctrl (WAIT=2) with a behavioural async SRAM.
module tb_sram_mem_ctrl;

   logic        clk = 0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, wdata, rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_we_n, sram_oe_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:63];

   sram_mem_ctrl #(.ADDR_W(32), .SRAM_ADDR_W(18), .BASE(1024), .WAIT(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   always #5 clk = ~clk;

   // Async SRAM: writes on rising WE, reads whenever OE is low
   always @(posedge sram_we_n) if (sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_o;
   assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1; wr_en = 0; rd_en = 0; address = 0; wdata = 0;
      repeat (2) step();
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
      checks++; if (sram_dq_o !== 16'h0) begin errors++; $display("FAIL reset_dq_o got %h exp 0", sram_dq_o); end
      checks++; if ({sram_dq_oe, sram_we_n, sram_oe_n} !== 3'b011) begin errors++; $display("FAIL reset_strobes got %b exp 011", {sram_dq_oe, sram_we_n, sram_oe_n}); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
      rst = 0;
      step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", ready); end
   endtask

   task automatic test_store();
      logic [17:0] ea [4];
      logic [15:0] ed [4];
      logic        ew [4];
      ea = '{18'd4, 18'd4, 18'd5, 18'd5};
      ed = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
      ew = '{1'b0, 1'b1, 1'b0, 1'b1};
      wr_en = 1; address = 32'd1032; wdata = 32'hDEADBEEF;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL store_ready_req got %b exp 0", ready); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (sram_addr !== ea[i] || sram_dq_o !== ed[i] || sram_we_n !== ew[i] || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL store_phase%0d got addr=%0d dq=%h we_n=%b oe=%b oe_n=%b rdy=%b exp addr=%0d dq=%h we_n=%b oe=1 oe_n=1 rdy=0",
                     i, sram_addr, sram_dq_o, sram_we_n, sram_dq_oe, sram_oe_n, ready, ea[i], ed[i], ew[i]);
         end
      end
      step();
      checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL store_done got rdy=%b we_n=%b oe=%b exp 1 1 0", ready, sram_we_n, sram_dq_oe); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", rdata); end
      wr_en = 0;
      step();
      checks++; if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin errors++; $display("FAIL store_mem got %h_%h exp dead_beef", mem[5], mem[4]); end
   endtask

   task automatic test_load();
      logic [17:0] ea [4];
      ea = '{18'd4, 18'd4, 18'd5, 18'd5};
      rd_en = 1; address = 32'd1033;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (sram_addr !== ea[i] || sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL load_phase%0d got addr=%0d oe_n=%b oe=%b we_n=%b rdy=%b exp addr=%0d 0 0 1 0",
                     i, sram_addr, sram_oe_n, sram_dq_oe, sram_we_n, ready, ea[i]);
         end
      end
      step();
      checks++; if (rdata !== 32'hDEADBEEF || ready !== 1'b1 || sram_oe_n !== 1'b1) begin errors++; $display("FAIL load_done got rdata=%h rdy=%b oe_n=%b exp deadbeef 1 1", rdata, ready, sram_oe_n); end
      rd_en = 0;
      step();
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold got %h exp deadbeef", rdata); end
   endtask

   task automatic test_back_to_back();
      wr_en = 1; address = 32'd1024; wdata = 32'h12345678;
      repeat (5) step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_store_done got rdy=%b exp 1", ready); end
      wr_en = 0; rd_en = 1;
      step();
      checks++; if (ready !== 1'b0 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin errors++; $display("FAIL b2b_idle got rdy=%b we_n=%b oe_n=%b exp 0 1 1", ready, sram_we_n, sram_oe_n); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b0 || sram_addr !== 18'(i / 2)) begin
            errors++;
            $display("FAIL b2b_load%0d got we_n=%b oe_n=%b addr=%0d exp 1 0 %0d", i, sram_we_n, sram_oe_n, sram_addr, i / 2);
         end
      end
      step();
      checks++; if (rdata !== 32'h12345678 || ready !== 1'b1) begin errors++; $display("FAIL b2b_rdata got %h rdy=%b exp 12345678 1", rdata, ready); end
      rd_en = 0;
      step();
   endtask

   task automatic test_both();
      logic ew [4];
      ew = '{1'b0, 1'b1, 1'b0, 1'b1};
      wr_en = 1; rd_en = 1; address = 32'd1040; wdata = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (sram_we_n !== ew[i] || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b1) begin
            errors++;
            $display("FAIL both_phase%0d got we_n=%b oe_n=%b oe=%b exp %b 1 1", i, sram_we_n, sram_oe_n, sram_dq_oe, ew[i]);
         end
      end
      step();
      checks++; if (rdata !== 32'h12345678 || ready !== 1'b1) begin errors++; $display("FAIL both_rdata got %h rdy=%b exp 12345678 1", rdata, ready); end
      wr_en = 0; rd_en = 0;
      step();
      checks++; if (mem[8] !== 16'hF00D || mem[9] !== 16'hCAFE) begin errors++; $display("FAIL both_mem got %h_%h exp cafe_f00d", mem[9], mem[8]); end
   endtask

   task automatic test_reset_mid();
      rd_en = 1; address = 32'd1032;
      repeat (3) step();
      checks++; if (rdata !== 32'h1234BEEF || sram_oe_n !== 1'b0 || sram_addr !== 18'd5) begin errors++; $display("FAIL mid_partial got rdata=%h oe_n=%b addr=%0d exp 1234beef 0 5", rdata, sram_oe_n, sram_addr); end
      rst = 1;
      #1;
      checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL mid_rst got we_n=%b oe_n=%b oe=%b rdata=%h exp 1 1 0 0", sram_we_n, sram_oe_n, sram_dq_oe, rdata); end
      rd_en = 0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", ready); end
      step();
      rst = 0;
      step();
      checks++; if (ready !== 1'b1 || sram_oe_n !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL mid_after got rdy=%b oe_n=%b rdata=%h exp 1 1 0", ready, sram_oe_n, rdata); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0;
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_both();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
